// File: rtl/mealy_seq_ctrl_if.sv
// Bundle between the sequencer, its host and the one Mealy FSM instance it drives.
// Host and FSM pins share one interface so a bench can bind both sides at once.
interface mealy_seq_ctrl_if #(
  parameter int MAX_LEN = 16,
  parameter int SW_W    = 2,
  parameter int ST_W    = 3
);
  // Handshake: start is a one-cycle request that is only taken while busy=0.
  // Taking it raises busy on the next cycle. A run then ends with exactly one
  // of three things: a done pulse, an err pulse, or an abort, and busy drops
  // at that point. A start seen while busy=1 is dropped, not queued.
  logic                     start;
  logic                     abort;
  logic [ST_W-1:0]          init_state;
  logic [4:0]               seq_len;
  logic [MAX_LEN*SW_W-1:0]  seq_data;

  logic                     fsm_reset;
  logic [ST_W-1:0]          fsm_state_in;
  logic [SW_W-1:0]          fsm_sw_in;
  logic                     fsm_ctrl;
  logic [ST_W-1:0]          fsm_state;
  logic                     fsm_out;

  logic                     busy;
  logic                     done;
  logic                     err;
  logic [MAX_LEN-1:0]       out_bits;
  logic [ST_W-1:0]          final_state;
  logic [4:0]               steps_done;
  logic [2:0]               dbg_state;

  modport master (
    output start, abort, init_state, seq_len, seq_data, fsm_state, fsm_out,
    input  fsm_reset, fsm_state_in, fsm_sw_in, fsm_ctrl,
    input  busy, done, err, out_bits, final_state, steps_done, dbg_state
  );

  modport slave (
    input  start, abort, init_state, seq_len, seq_data, fsm_state, fsm_out,
    output fsm_reset, fsm_state_in, fsm_sw_in, fsm_ctrl,
    output busy, done, err, out_bits, final_state, steps_done, dbg_state
  );
endinterface

// File: rtl/mealy_seq_ctrl.sv
// Sequencer that loads a Mealy FSM with an initial state, steps it through a
// stored switch sequence and captures each step's output bit and end state.
module mealy_seq_ctrl #(
  parameter int MAX_LEN    = 16,
  parameter int SW_W       = 2,
  parameter int ST_W       = 3,
  parameter int NUM_STATES = 3
) (
  input  logic           clk,
  input  logic           reset,
  mealy_seq_ctrl_if.slave bus
);
  localparam int CNT_W = 5;
  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_STEP, S_CAPT, S_DONE
  } state_t;

  state_t             r_state;
  logic [ST_W-1:0]    r_init;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_idx;
  logic [SW_W-1:0]    r_seq [MAX_LEN];

  logic               r_fsm_reset;
  logic [ST_W-1:0]    r_fsm_state_in;
  logic [SW_W-1:0]    r_fsm_sw_in;
  logic               r_fsm_ctrl;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [MAX_LEN-1:0] r_out_bits;
  logic [ST_W-1:0]    r_final_state;
  logic [CNT_W-1:0]   r_steps_done;

  logic [CNT_W-1:0]   w_len_clamped;
  logic [CNT_W-1:0]   w_idx_nxt;
  logic               w_init_ok;
  logic               w_state_ok;
  logic               w_last;

  assign w_len_clamped = (bus.seq_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : bus.seq_len;
  assign w_idx_nxt     = r_idx + CNT_W'(1);
  assign w_init_ok     = int'(bus.init_state) < NUM_STATES;
  assign w_state_ok    = int'(bus.fsm_state) < NUM_STATES;
  assign w_last        = (r_idx == r_len - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_init         <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      for (int i = 0; i < MAX_LEN; i++) r_seq[i] <= '0;
      r_fsm_reset    <= 1'b0;
      r_fsm_state_in <= '0;
      r_fsm_sw_in    <= '0;
      r_fsm_ctrl     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_out_bits     <= '0;
      r_final_state  <= '0;
      r_steps_done   <= '0;
    end else begin
      r_fsm_reset <= 1'b0;
      r_fsm_ctrl  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_fsm_sw_in <= '0;
          if (bus.start) begin
            if (w_init_ok) begin
              r_init         <= bus.init_state;
              r_len          <= w_len_clamped;
              for (int i = 0; i < MAX_LEN; i++) r_seq[i] <= bus.seq_data[SW_W*i +: SW_W];
              r_out_bits     <= '0;
              r_steps_done   <= '0;
              r_busy         <= 1'b1;
              r_fsm_reset    <= 1'b1;
              r_fsm_state_in <= bus.init_state;
              r_state        <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_LOAD: r_state <= S_SETTLE;

        // The FSM has had one edge with reset high; it must now hold init.
        S_SETTLE: begin
          if (bus.fsm_state != r_init) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_len == '0) begin
            r_final_state <= bus.fsm_state;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_idx       <= '0;
            r_fsm_sw_in <= r_seq[0];
            r_fsm_ctrl  <= 1'b1;
            r_state     <= S_STEP;
          end
        end

        S_STEP: r_state <= S_CAPT;

        S_CAPT: begin
          r_out_bits[r_idx[IDX_W-1:0]] <= bus.fsm_out;
          r_steps_done                 <= w_idx_nxt;
          if (!w_state_ok) begin
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm_sw_in <= '0;
            r_state     <= S_IDLE;
          end else if (w_last) begin
            r_final_state <= bus.fsm_state;
            r_done        <= 1'b1;
            r_fsm_sw_in   <= '0;
            r_state       <= S_DONE;
          end else begin
            r_idx       <= w_idx_nxt;
            r_fsm_sw_in <= r_seq[w_idx_nxt[IDX_W-1:0]];
            r_fsm_ctrl  <= 1'b1;
            r_state     <= S_STEP;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      // Abort overrides the transition above but keeps whatever CAPT captured.
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_fsm_ctrl  <= 1'b0;
        r_fsm_reset <= 1'b0;
        r_fsm_sw_in <= '0;
      end
    end
  end

  // Gating with abort drops step/load enables in the abort cycle itself.
  assign bus.fsm_reset    = r_fsm_reset & ~bus.abort;
  assign bus.fsm_ctrl     = r_fsm_ctrl & ~bus.abort;
  assign bus.fsm_state_in = r_fsm_state_in;
  assign bus.fsm_sw_in    = r_fsm_sw_in;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.out_bits     = r_out_bits;
  assign bus.final_state  = r_final_state;
  assign bus.steps_done   = r_steps_done;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Bench for mealy_seq_ctrl: a table-driven FSM plant on the FSM pins, directed
// scenarios, then random runs compared against a sequence-level reference model.
module tb_mealy_seq_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   ctrl_cnt;
  int   rst_cnt;

  mealy_seq_ctrl_if bus ();

  mealy_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transition table of the controlled FSM: returns {next_state, out}.
  function automatic logic [3:0] fsm_next(input logic [2:0] s, input logic [1:0] sw);
    case (s)
      3'd0: case (sw)
              2'd0:    return {3'd1, 1'b1};
              2'd1:    return {3'd2, 1'b0};
              2'd2:    return {3'd1, 1'b1};
              default: return {3'd0, 1'b0};
            endcase
      3'd1: return (sw == 2'd3) ? {3'd0, 1'b0} : {3'd2, 1'b1};
      3'd2: begin
        if (sw <= 2'd1) return {3'd0, 1'b1};
        if (sw == 2'd2) return {3'd2, 1'b0};
        return {3'd0, 1'b0};
      end
      default: return {3'd0, 1'b0};
    endcase
  endfunction

  // Plant: loads state_in on reset, steps on ctrl; fault knobs corrupt it.
  logic [2:0] p_state = 3'd0;
  logic       p_out   = 1'b0;
  int         p_steps = 0;
  bit         fault_load = 1'b0;
  int         fault_step = -1;
  logic [3:0] p_nx;

  assign p_nx          = fsm_next(p_state, bus.fsm_sw_in);
  assign bus.fsm_state = p_state;
  assign bus.fsm_out   = p_out;

  always @(posedge clk) begin
    if (bus.fsm_reset) begin
      p_state <= fault_load ? bus.fsm_state_in + 3'd1 : bus.fsm_state_in;
      p_out   <= 1'b0;
      p_steps <= 0;
    end else if (bus.fsm_ctrl) begin
      p_state <= (p_steps == fault_step) ? 3'd7 : p_nx[3:1];
      p_out   <= p_nx[0];
      p_steps <= p_steps + 1;
    end
  end

  always @(posedge clk) begin
    if (bus.fsm_ctrl)  ctrl_cnt <= ctrl_cnt + 1;
    if (bus.fsm_reset) rst_cnt  <= rst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy),         0);
    check({tag, "_done"},   32'(bus.done),         0);
    check({tag, "_err"},    32'(bus.err),          0);
    check({tag, "_bits"},   32'(bus.out_bits),     0);
    check({tag, "_final"},  32'(bus.final_state),  0);
    check({tag, "_steps"},  32'(bus.steps_done),   0);
    check({tag, "_frst"},   32'(bus.fsm_reset),    0);
    check({tag, "_fctrl"},  32'(bus.fsm_ctrl),     0);
    check({tag, "_fsw"},    32'(bus.fsm_sw_in),    0);
    check({tag, "_fsin"},   32'(bus.fsm_state_in), 0);
  endtask

  // Sequence-level reference: clamp length, walk the table, collect output bits.
  task automatic model(input logic [2:0] init, input logic [4:0] len, input logic [31:0] data,
                       output logic [15:0] bits, output logic [2:0] fin, output logic [4:0] n);
    logic [2:0] s;
    logic [3:0] r;
    n    = (len > 5'd16) ? 5'd16 : len;
    s    = init;
    bits = '0;
    for (int i = 0; i < int'(n); i++) begin
      r       = fsm_next(s, data[2*i +: 2]);
      s       = r[3:1];
      bits[i] = r[0];
    end
    fin = s;
  endtask

  // One run; cyc is the cycle (start edge = cycle 1) where done/err was seen.
  task automatic run(input logic [2:0] init, input logic [4:0] len, input logic [31:0] data,
                     input int restart_at, input int abort_at, input int reset_at,
                     output int cyc, output bit saw_done, output bit saw_err, output int pulses);
    int c0;
    @(negedge clk);
    bus.init_state = init;
    bus.seq_len    = len;
    bus.seq_data   = data;
    bus.start      = 1'b1;
    c0             = ctrl_cnt;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.init_state = 3'($urandom_range(0, 7));
    bus.seq_len    = 5'($urandom());
    bus.seq_data   = $urandom();
    cyc      = 1;
    saw_done = 1'b0;
    saw_err  = 1'b0;
    while (cyc < 60) begin
      if (bus.done) saw_done = 1'b1;
      if (bus.err)  saw_err  = 1'b1;
      if (saw_done || saw_err) break;
      if ((abort_at > 0 && cyc >= abort_at + 4) || (reset_at > 0 && cyc >= reset_at + 4)) break;
      if (cyc == restart_at) begin
        bus.start      = 1'b1;
        bus.init_state = 3'd2;
      end
      if (cyc == abort_at) bus.abort = 1'b1;
      if (cyc == reset_at) begin
        #2 reset = 1'b1;
        #1 check_zero("mid_rst");
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      reset     = 1'b0;
      cyc++;
    end
    pulses = ctrl_cnt - c0;
  endtask

  initial begin
    int          cyc;
    int          pulses;
    int          r0;
    bit          sd;
    bit          se;
    logic [15:0] eb;
    logic [2:0]  ef;
    logic [4:0]  en;
    logic [2:0]  ri;
    logic [4:0]  rl;
    logic [31:0] rd;

    n_vec = 0;
    n_err = 0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.init_state = '0;
    bus.seq_len    = '0;
    bus.seq_data   = '0;
    reset          = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("por");
    reset = 1'b0;
    @(negedge clk);
    check_zero("por_rel");

    // init=0, sw=0,0,2,3
    run(3'd0, 5'd4, 32'h0000_00E0, 0, 0, 0, cyc, sd, se, pulses);
    check("d4_done",  32'(sd), 1);
    check("d4_err",   32'(se), 0);
    check("d4_lat",   32'(cyc), 11);
    check("d4_bits",  32'(bus.out_bits), 32'h3);
    check("d4_final", 32'(bus.final_state), 0);
    check("d4_steps", 32'(bus.steps_done), 4);
    check("d4_ctrl",  32'(pulses), 4);
    check("d4_busy_in_done", 32'(bus.busy), 1);
    @(negedge clk);
    check("d4_busy_after", 32'(bus.busy), 0);
    check("d4_done_pulse", 32'(bus.done), 0);

    // N=0 from state 1
    run(3'd1, 5'd0, $urandom(), 0, 0, 0, cyc, sd, se, pulses);
    check("n0_done",  32'(sd), 1);
    check("n0_lat",   32'(cyc), 3);
    check("n0_final", 32'(bus.final_state), 1);
    check("n0_bits",  32'(bus.out_bits), 0);
    check("n0_ctrl",  32'(pulses), 0);

    // Illegal init
    r0 = rst_cnt;
    run(3'd5, 5'd4, $urandom(), 0, 0, 0, cyc, sd, se, pulses);
    check("bad_err",  32'(se), 1);
    check("bad_lat",  32'(cyc), 1);
    check("bad_busy", 32'(bus.busy), 0);
    check("bad_frst", 32'(rst_cnt - r0), 0);

    // Abort in CAPT of step 2
    rd = $urandom();
    run(3'd0, 5'd16, rd, 0, 8, 0, cyc, sd, se, pulses);
    model(3'd0, 5'd3, rd, eb, ef, en);
    check("ab_done",  32'(sd), 0);
    check("ab_err",   32'(se), 0);
    check("ab_busy",  32'(bus.busy), 0);
    check("ab_steps", 32'(bus.steps_done), 3);
    check("ab_bits",  32'(bus.out_bits), 32'(eb));
    check("ab_ctrl",  32'(pulses), 3);
    check("ab_fctrl", 32'(bus.fsm_ctrl), 0);

    // Second start while busy must be ignored
    rd = $urandom();
    run(3'd0, 5'd3, rd, 2, 0, 0, cyc, sd, se, pulses);
    model(3'd0, 5'd3, rd, eb, ef, en);
    check("rs_done",  32'(sd), 1);
    check("rs_lat",   32'(cyc), 9);
    check("rs_bits",  32'(bus.out_bits), 32'(eb));
    check("rs_final", 32'(bus.final_state), 32'(ef));
    repeat (2) @(negedge clk);
    check("rs_idle",  32'(bus.busy), 0);

    // Async reset during STEP of step 1
    run(3'd2, 5'd8, $urandom(), 0, 0, 5, cyc, sd, se, pulses);
    check("rst_done", 32'(sd), 0);
    check("rst_err",  32'(se), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_steps", 32'(bus.steps_done), 0);

    // seq_len above MAX_LEN clamps to 16 steps
    rd = $urandom();
    run(3'd1, 5'd20, rd, 0, 0, 0, cyc, sd, se, pulses);
    model(3'd1, 5'd20, rd, eb, ef, en);
    check("cl_done",  32'(sd), 1);
    check("cl_lat",   32'(cyc), 35);
    check("cl_steps", 32'(bus.steps_done), 16);
    check("cl_ctrl",  32'(pulses), 16);
    check("cl_bits",  32'(bus.out_bits), 32'(eb));
    check("cl_final", 32'(bus.final_state), 32'(ef));

    // Plant fails to load init
    fault_load = 1'b1;
    run(3'd0, 5'd4, $urandom(), 0, 0, 0, cyc, sd, se, pulses);
    fault_load = 1'b0;
    check("ld_err",  32'(se), 1);
    check("ld_lat",  32'(cyc), 3);
    check("ld_busy", 32'(bus.busy), 0);
    check("ld_ctrl", 32'(pulses), 0);

    // Plant reaches an illegal state after step 1
    fault_step = 1;
    rd = $urandom();
    run(3'd0, 5'd5, rd, 0, 0, 0, cyc, sd, se, pulses);
    fault_step = -1;
    model(3'd0, 5'd2, rd, eb, ef, en);
    check("st_err",   32'(se), 1);
    check("st_done",  32'(sd), 0);
    check("st_lat",   32'(cyc), 7);
    check("st_steps", 32'(bus.steps_done), 2);
    check("st_bits",  32'(bus.out_bits), 32'(eb));

    // Random runs
    for (int k = 0; k < 25; k++) begin
      ri = 3'($urandom_range(0, 2));
      rl = 5'($urandom_range(0, 20));
      rd = $urandom();
      model(ri, rl, rd, eb, ef, en);
      run(ri, rl, rd, 0, 0, 0, cyc, sd, se, pulses);
      check("rnd_done",  32'(sd), 1);
      check("rnd_lat",   32'(cyc), 32'(3 + 2 * int'(en)));
      check("rnd_bits",  32'(bus.out_bits), 32'(eb));
      check("rnd_final", 32'(bus.final_state), 32'(ef));
      check("rnd_steps", 32'(bus.steps_done), 32'(en));
      check("rnd_ctrl",  32'(pulses), 32'(en));
      check("rnd_sw0",   32'(bus.fsm_sw_in), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
